sisc_ctrl_gen2: RTL and testbench
=================================

# sisc_ctrl_gen2

Second-generation SISC multi-cycle control FSM, with parametrised condition-code and mode width. It is a drop-in replacement for the existing controller in the SISC datapath.
- Adds a data-memory request/acknowledge handshake with wait states and a bounded timeout.
- Adds branch early-exit from DECODE.
- Replaces the simulation-only stop with a synthesisable HALT state plus halted/fault flags.
- Adds a retired-instruction counter.

## Interface
- MMW, 4: width of `mm` and `stat`.
- CNTW, 16: width of `instr_count`.
- WAIT_MAX, 15: maximum MEM-state cycles without `dm_ack` before fault; must be ≥1.
- IMM_MM, 8: `mm` value selecting immediate / indexed mode.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_f  in  1  reset; asynchronous, active-high.
- opcode  in  4  IR opcode field, valid from DECODE onward.
- mm  in  MMW  IR mode / condition-mask field.
- stat  in  MMW  ALU status flags.
- dm_ack  in  1  data memory completed access this cycle.
- rf_we  out  1  register-file write enable.
- alu_op  out  2  ALU operation select.
- wb_sel  out  2  write-back source select.
- rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel, mux_16_sel, swap_ctrl, mux4_swap_sel  out  1 each  datapath selects/enables with existing meanings.
- dm_we  out  1  data-memory write request.
- dm_re  out  1  data-memory read request.
- halted  out  1  FSM in HALT.
- fault  out  1  sticky: illegal opcode or memory timeout.
- instr_count  out  CNTW  retired instructions.

## Operation
States: RESET, START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.

Transitions:
- RESET→START→FETCH→DECODE.
- In DECODE:
  - Branch opcodes (BRA=4, BRR=5, BNE=6, BNR=7), HLT (15) and NOOP (0) exit DECODE; see Timing.
  - Illegal opcode (9–14) → HALT with `fault`=1.
  - All others → EXECUTE→MEM.
- MEM→WRITEBACK when no memory access is pending or `dm_ack`=1.
- WRITEBACK→FETCH.
- HALT is exited only by reset.

Outputs are Moore outputs decoded from the state register and from `opcode_q` / `mm_q`, which are captured on DECODE exit. Any output not listed below is 0.

Per-state outputs:
- RESET: `pc_rst`=1, `alu_op`=10.
- FETCH: `ir_load`=1, `pc_write`=1.
- DECODE:
  - STR/SWP: `rb_sel`=1.
  - Branch taken: `pc_sel`=1, `pc_write`=1, `br_sel`=1 for BRA/BNE and 0 for BRR/BNR.
  - Taken rule: BRA/BRR when (`stat` & `mm`)≠0; BNE/BNR when (`stat` & `mm`)=0.
- EXECUTE:
  - ALU_OP(8): `alu_op`=01 if `mm_q`=IMM_MM, else 00.
  - LOD(1)/STR(2): `alu_op`=11 if `mm_q`=IMM_MM, else 10; LOD also drives `wb_sel`=1.
  - SWP(3): `swap_ctrl`=1, `wb_sel`=2.
- MEM:
  - LOD: `dm_re`=1, `wb_sel`=1, `mux_16_sel`=(`mm_q`=IMM_MM).
  - STR: `dm_we`=1.
  - `dm_re`/`dm_we` are held every MEM cycle until `dm_ack`.
  - SWP: `rf_we`=1, `wb_sel`=2.
- WRITEBACK:
  - ALU_OP/LOD: `rf_we`=1; LOD keeps `wb_sel`=1 and `mux_16_sel`.
  - SWP: `rf_we`=1, `wb_sel`=3, `mux4_swap_sel`=1.
- HALT: `halted`=1.

Memory wait counter:
- Width ⌈log2(WAIT_MAX+1)⌉; clears on MEM entry and increments each MEM cycle without `dm_ack`.
- On reaching WAIT_MAX with `dm_ack`=0: go to HALT, set `fault`=1, drop `dm_we`/`dm_re`.

`instr_count` increments by 1 each time FETCH is entered from WRITEBACK or DECODE. It wraps modulo 2^CNTW and does not count the first FETCH after START.

## Timing
- `rst_f`=1 at any time, including mid-MEM:
  - State immediately RESET; all outputs 0 except `pc_rst`=1 and `alu_op`=10.
  - `fault`, `instr_count` and the wait counter clear.
- First FETCH is the 2nd rising edge after `rst_f` falls (RESET→START→FETCH).
- Latencies in cycles:
  - Branch (taken or not): 2 (FETCH, DECODE).
  - NOOP: 2.
  - ALU_OP and SWP: 5.
  - LOD/STR: 5 + number of wait cycles.
- `dm_ack` is sampled on the rising edge; `dm_ack`=1 in the first MEM cycle gives zero wait.
- `dm_ack` outside MEM is ignored.
- HLT: `halted` rises 1 cycle after DECODE.
- `fault` and `halted` are registered; the wait counter is sticky until reset.
- `stat` is sampled only in DECODE; a simultaneous `stat` change in DECODE uses the value present at that edge.

## Test plan
- Reset mid-MEM of a STR with `dm_ack`=0 → `dm_we` drops asynchronously, `pc_rst`=1, state RESET; FETCH occurs 2 cycles after release, `instr_count`=0.
- ALU_OP with `mm`=8, then with `mm`=0 → EXECUTE `alu_op`=01, then 00; `rf_we`=1 only in WRITEBACK; `instr_count` ends at 2.
- BRA, `mm`=0001, `stat`=0001 → DECODE `pc_write`=1, `pc_sel`=1, `br_sel`=1, next state FETCH. BNR with the same values → `pc_write`=0, next FETCH.
- LOD, `mm`=0, `dm_ack` asserted on the 3rd MEM cycle → `dm_re` high exactly 3 cycles, `mux_16_sel`=0, then WRITEBACK `rf_we`=1.
- STR with WAIT_MAX=4 and `dm_ack` held 0 → after 4 MEM cycles state HALT, `fault`=1, `halted`=1, `dm_we`=0; stays until reset.
- SWP → EXECUTE `swap_ctrl`=1/`wb_sel`=2; MEM `rf_we`=1; WRITEBACK `wb_sel`=3, `mux4_swap_sel`=1, `rf_we`=1. Opcode 12 → HALT with `fault`=1. HLT → `halted`=1, `fault`=0.

Source files
------------

// File: rtl/sisc_ctrl_gen2.sv
// Multi-cycle SISC control FSM: fetch/decode/execute/mem/writeback sequencing with
// data-memory handshake, timeout fault, synthesisable HALT and retired-instruction count.
module sisc_ctrl_gen2 #(
  parameter int MMW      = 4,
  parameter int CNTW     = 16,
  parameter int WAIT_MAX = 15,
  parameter int IMM_MM   = 8
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [3:0]      opcode,
  input  logic [MMW-1:0]  mm,
  input  logic [MMW-1:0]  stat,
  input  logic            dm_ack,
  output logic            rf_we,
  output logic [1:0]      alu_op,
  output logic [1:0]      wb_sel,
  output logic            rb_sel,
  output logic            pc_sel,
  output logic            pc_write,
  output logic            pc_rst,
  output logic            ir_load,
  output logic            br_sel,
  output logic            mux_16_sel,
  output logic            swap_ctrl,
  output logic            mux4_swap_sel,
  output logic            dm_we,
  output logic            dm_re,
  output logic            halted,
  output logic            fault,
  output logic [CNTW-1:0] instr_count,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    S_RESET, S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  localparam int WCW = $clog2(WAIT_MAX + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_MAX - 1);
  localparam logic [MMW-1:0] IMM = MMW'(IMM_MM);

  state_t          state, state_nx;
  logic [3:0]      opcode_q;
  logic [MMW-1:0]  mm_q;
  logic [WCW-1:0]  wait_cnt;
  logic            fault_set, count_en;
  logic            is_branch, is_illegal, cond_hit, br_taken, imm_q, mem_pending;

  assign dbg_state   = state;
  assign is_branch   = (opcode[3:2] == 2'b01);
  assign is_illegal  = (opcode >= 4'd9) && (opcode <= 4'd14);
  assign cond_hit    = |(stat & mm);
  // BNE/BNR (opcode bit 1 set) take the branch on an empty mask match
  assign br_taken    = opcode[1] ? !cond_hit : cond_hit;
  assign imm_q       = (mm_q == IMM);
  assign mem_pending = (opcode_q == OP_LOD) || (opcode_q == OP_STR);

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      state       <= S_RESET;
      opcode_q    <= '0;
      mm_q        <= '0;
      wait_cnt    <= '0;
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) begin
        opcode_q <= opcode;
        mm_q     <= mm;
      end
      if (state == S_EXECUTE)
        wait_cnt <= '0;
      else if (state == S_MEM && !dm_ack)
        wait_cnt <= wait_cnt + 1'b1;
      if (fault_set)
        fault <= 1'b1;
      if (count_en)
        instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    state_nx      = state;
    fault_set     = 1'b0;
    rf_we         = 1'b0;
    alu_op        = 2'b00;
    wb_sel        = 2'b00;
    rb_sel        = 1'b0;
    pc_sel        = 1'b0;
    pc_write      = 1'b0;
    pc_rst        = 1'b0;
    ir_load       = 1'b0;
    br_sel        = 1'b0;
    mux_16_sel    = 1'b0;
    swap_ctrl     = 1'b0;
    mux4_swap_sel = 1'b0;
    dm_we         = 1'b0;
    dm_re         = 1'b0;
    halted        = 1'b0;
    case (state)
      S_RESET: begin
        pc_rst   = 1'b1;
        alu_op   = 2'b10;
        state_nx = S_START;
      end
      S_START: state_nx = S_FETCH;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        rb_sel = (opcode == OP_STR) || (opcode == OP_SWP);
        if (is_branch) begin
          if (br_taken) begin
            pc_sel   = 1'b1;
            pc_write = 1'b1;
            br_sel   = !opcode[0];
          end
          state_nx = S_FETCH;
        end else if (opcode == OP_NOOP) begin
          state_nx = S_FETCH;
        end else if (opcode == OP_HLT) begin
          state_nx = S_HALT;
        end else if (is_illegal) begin
          state_nx  = S_HALT;
          fault_set = 1'b1;
        end else begin
          state_nx = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        case (opcode_q)
          OP_ALU: alu_op = imm_q ? 2'b01 : 2'b00;
          OP_LOD: begin
            alu_op = imm_q ? 2'b11 : 2'b10;
            wb_sel = 2'd1;
          end
          OP_STR: alu_op = imm_q ? 2'b11 : 2'b10;
          OP_SWP: begin
            swap_ctrl = 1'b1;
            wb_sel    = 2'd2;
          end
          default: ;
        endcase
        state_nx = S_MEM;
      end
      S_MEM: begin
        case (opcode_q)
          OP_LOD: begin
            dm_re      = 1'b1;
            wb_sel     = 2'd1;
            mux_16_sel = imm_q;
          end
          OP_STR: dm_we = 1'b1;
          OP_SWP: begin
            rf_we  = 1'b1;
            wb_sel = 2'd2;
          end
          default: ;
        endcase
        // Timeout fires on the WAIT_MAX-th unacknowledged cycle
        if (!mem_pending || dm_ack) begin
          state_nx = S_WRITEBACK;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx  = S_HALT;
          fault_set = 1'b1;
        end
      end
      S_WRITEBACK: begin
        case (opcode_q)
          OP_ALU: rf_we = 1'b1;
          OP_LOD: begin
            rf_we      = 1'b1;
            wb_sel     = 2'd1;
            mux_16_sel = imm_q;
          end
          OP_SWP: begin
            rf_we         = 1'b1;
            wb_sel        = 2'd3;
            mux4_swap_sel = 1'b1;
          end
          default: ;
        endcase
        state_nx = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_RESET;
    endcase
    count_en = (state_nx == S_FETCH) && ((state == S_DECODE) || (state == S_WRITEBACK));
  end

endmodule

// File: tb/tb_sisc_ctrl_gen2.sv
// Bench for sisc_ctrl_gen2: an instruction-level model queues the expected output
// vector of every cycle; a negedge monitor pops and compares against the DUT.
module tb_sisc_ctrl_gen2;
  localparam int MMW      = 4;
  localparam int CNTW     = 16;
  localparam int WAIT_MAX = 4;
  localparam int IMM_MM   = 8;
  localparam int W        = 34;
  localparam int NEVER    = 1000;

  typedef struct packed {
    logic            rf_we;
    logic [1:0]      alu_op;
    logic [1:0]      wb_sel;
    logic            rb_sel;
    logic            pc_sel;
    logic            pc_write;
    logic            pc_rst;
    logic            ir_load;
    logic            br_sel;
    logic            mux_16_sel;
    logic            swap_ctrl;
    logic            mux4_swap_sel;
    logic            dm_we;
    logic            dm_re;
    logic            halted;
    logic            fault;
    logic [CNTW-1:0] cnt;
  } out_t;

  logic            clk = 1'b0;
  logic            rst_f = 1'b0;
  logic [3:0]      opcode = '0;
  logic [MMW-1:0]  mm = '0;
  logic [MMW-1:0]  stat = '0;
  logic            dm_ack = 1'b0;
  logic            rf_we, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel;
  logic            mux_16_sel, swap_ctrl, mux4_swap_sel, dm_we, dm_re, halted, fault;
  logic [1:0]      alu_op, wb_sel;
  logic [CNTW-1:0] instr_count;
  logic [2:0]      dbg_state;

  logic [W-1:0]    exp_q[$];
  logic [W-1:0]    mon_e, mon_a;
  int              n_total = 0;
  int              n_pass = 0;
  logic [CNTW-1:0] m_count = '0;
  bit              m_halted = 1'b0;
  bit              m_fault = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  sisc_ctrl_gen2 #(.MMW(MMW), .CNTW(CNTW), .WAIT_MAX(WAIT_MAX), .IMM_MM(IMM_MM)) dut (
    .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat), .dm_ack(dm_ack),
    .rf_we(rf_we), .alu_op(alu_op), .wb_sel(wb_sel), .rb_sel(rb_sel), .pc_sel(pc_sel),
    .pc_write(pc_write), .pc_rst(pc_rst), .ir_load(ir_load), .br_sel(br_sel),
    .mux_16_sel(mux_16_sel), .swap_ctrl(swap_ctrl), .mux4_swap_sel(mux4_swap_sel),
    .dm_we(dm_we), .dm_re(dm_re), .halted(halted), .fault(fault),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  function automatic out_t act_vec();
    out_t a;
    a.rf_we = rf_we; a.alu_op = alu_op; a.wb_sel = wb_sel; a.rb_sel = rb_sel;
    a.pc_sel = pc_sel; a.pc_write = pc_write; a.pc_rst = pc_rst; a.ir_load = ir_load;
    a.br_sel = br_sel; a.mux_16_sel = mux_16_sel; a.swap_ctrl = swap_ctrl;
    a.mux4_swap_sel = mux4_swap_sel; a.dm_we = dm_we; a.dm_re = dm_re;
    a.halted = halted; a.fault = fault; a.cnt = instr_count;
    return a;
  endfunction

  function automatic out_t blank();
    out_t o;
    o = '0;
    o.cnt = m_count;
    o.fault = m_fault;
    o.halted = m_halted;
    return o;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = act_vec();
      n_total++;
      if (mon_a === mon_e) n_pass++;
      else $display("FAIL out_vec t=%0t act=%h exp=%h", $time, mon_a, mon_e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h", name, act, exp);
  endtask

  task automatic push(input out_t o);
    exp_q.push_back(o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    opcode = 4'($urandom_range(0, 15));
    mm     = MMW'($urandom_range(0, 15));
    stat   = MMW'($urandom_range(0, 15));
    dm_ack = 1'($urandom_range(0, 1));
  endtask

  // driver: asynchronous reset, then RESET and START cycles
  task automatic do_reset();
    out_t o;
    rst_f = 1'b1;
    #1;
    check("rst_pc_rst", 32'(pc_rst), 32'd1);
    check("rst_alu_op", 32'(alu_op), 32'd2);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_re", 32'(dm_re), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    m_count = '0; m_halted = 1'b0; m_fault = 1'b0;
    tick();
    o = blank(); o.pc_rst = 1'b1; o.alu_op = 2'b10;
    push(o); tick();
    rst_f = 1'b0;
    push(o); tick();
    push(blank()); tick();
  endtask

  // driver: one instruction from FETCH; ack_wait = unacknowledged MEM cycles before dm_ack
  task automatic issue(input logic [3:0] op, input logic [MMW-1:0] mmv,
                       input logic [MMW-1:0] st, input int ack_wait, input int abort_k);
    out_t o;
    bit imm, taken, is_br;
    imm   = (mmv == MMW'(IMM_MM));
    is_br = (op >= 4 && op <= 7);
    opcode = op; mm = mmv; stat = st; dm_ack = 1'($urandom_range(0, 1));
    o = blank(); o.ir_load = 1'b1; o.pc_write = 1'b1;
    push(o); tick();
    dm_ack = 1'($urandom_range(0, 1));
    o = blank();
    if (op == 2 || op == 3) o.rb_sel = 1'b1;
    if (is_br) begin
      taken = (op <= 5) ? ((st & mmv) != 0) : ((st & mmv) == 0);
      o.pc_sel = taken; o.pc_write = taken;
      o.br_sel = taken && (op == 4 || op == 6);
    end
    push(o); tick();
    if (is_br || op == 0) begin m_count++; return; end
    if (op == 15) begin m_halted = 1'b1; return; end
    if (op >= 9) begin m_halted = 1'b1; m_fault = 1'b1; return; end
    scramble();
    o = blank();
    case (op)
      4'd8: o.alu_op = imm ? 2'b01 : 2'b00;
      4'd1: begin o.alu_op = imm ? 2'b11 : 2'b10; o.wb_sel = 2'd1; end
      4'd2: o.alu_op = imm ? 2'b11 : 2'b10;
      default: begin o.swap_ctrl = 1'b1; o.wb_sel = 2'd2; end
    endcase
    push(o); tick();
    if (op == 1 || op == 2) begin
      for (int k = 0; k < NEVER; k++) begin
        if (k == abort_k) return;
        scramble();
        dm_ack = (k == ack_wait);
        o = blank();
        if (op == 1) begin o.dm_re = 1'b1; o.wb_sel = 2'd1; o.mux_16_sel = imm; end
        else o.dm_we = 1'b1;
        push(o); tick();
        if (k == ack_wait) break;
        if (k == WAIT_MAX - 1) begin m_halted = 1'b1; m_fault = 1'b1; return; end
      end
    end else begin
      scramble();
      o = blank();
      if (op == 3) begin o.rf_we = 1'b1; o.wb_sel = 2'd2; end
      push(o); tick();
    end
    scramble();
    o = blank();
    case (op)
      4'd8: o.rf_we = 1'b1;
      4'd1: begin o.rf_we = 1'b1; o.wb_sel = 2'd1; o.mux_16_sel = imm; end
      4'd3: begin o.rf_we = 1'b1; o.wb_sel = 2'd3; o.mux4_swap_sel = 1'b1; end
      default: ;
    endcase
    push(o); tick();
    m_count++;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      scramble();
      push(blank()); tick();
    end
  endtask

  task automatic rand_instrs(input int n);
    logic [3:0] op;
    logic [MMW-1:0] mv;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 8));
      mv = ($urandom_range(0, 3) == 0) ? MMW'(IMM_MM) : MMW'($urandom_range(0, 15));
      issue(op, mv, MMW'($urandom_range(0, 15)), $urandom_range(0, WAIT_MAX - 1), -1);
    end
  endtask

  initial begin
    tick();
    do_reset();
    issue(4'd8, 4'd8, 4'd0, 0, -1);
    issue(4'd8, 4'd0, 4'd0, 0, -1);
    issue(4'd4, 4'd1, 4'd1, 0, -1);
    issue(4'd7, 4'd1, 4'd1, 0, -1);
    issue(4'd1, 4'd0, 4'd0, 2, -1);
    issue(4'd1, 4'd8, 4'd0, 0, -1);
    issue(4'd2, 4'd3, 4'd0, 1, -1);
    issue(4'd3, 4'd0, 4'd0, 0, -1);
    issue(4'd0, 4'd0, 4'd0, 0, -1);
    issue(4'd6, 4'd2, 4'd4, 0, -1);
    issue(4'd5, 4'd6, 4'd2, 0, -1);
    rand_instrs(40);
    // reset while a store waits for its acknowledge
    issue(4'd2, 4'd0, 4'd0, NEVER, 2);
    #2;
    check("pre_rst_dm_we", 32'(dm_we), 32'd1);
    do_reset();
    issue(4'd2, 4'd0, 4'd0, NEVER, -1);
    halt_cycles(5);
    do_reset();
    issue(4'd12, 4'd0, 4'd0, 0, -1);
    halt_cycles(3);
    do_reset();
    issue(4'd15, 4'd0, 4'd0, 0, -1);
    halt_cycles(3);
    do_reset();
    rand_instrs(10);
    repeat (3) @(negedge clk);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain act=%0d exp=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
